// File: rtl/frame_dma_reader_pkg.sv
// Shared types and constants for the frame-buffer DMA engines.
// Holds the FSM state encoding, burst geometry and the frame address-wrap helper.
package frame_dma_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DAT   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int         BURST_LEN    = 4;
   localparam logic [1:0] MEMLEN_BURST = 2'd3;
   localparam logic [1:0] LAST_WORD    = 2'd3;
   localparam int         SOF_BIT      = 24;
   localparam int         PIX_W        = 24;
   localparam int         ADDR_W       = 23;

   // Address of the burst after addr, wrapping to base at the end of the frame.
   function automatic logic [ADDR_W-1:0] next_burst_addr(
      input logic [ADDR_W-1:0] addr,
      input logic [ADDR_W-1:0] base,
      input logic [ADDR_W-1:0] end_addr
   );
      logic [ADDR_W-1:0] inc;
      inc = addr + ADDR_W'(BURST_LEN);
      if (inc == end_addr) begin
         return base;
      end else begin
         return inc;
      end
   endfunction

endpackage

// File: rtl/frame_dma_reader.sv
// Read-side frame-buffer DMA: fetches 4-word bursts from memory and streams the
// pixels into the output FIFO as {sof, rgb}, scanning the frame linearly with wrap.
module frame_dma_reader
   import frame_dma_reader_pkg::*;
#(
   parameter int BASE_ADDR   = 0,
   parameter int FRAME_WORDS = 307200
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              resync,
   output logic [24:0]       indat,
   output logic              wren,
   input  logic              full,
   output logic [ADDR_W-1:0] memaddr,
   input  logic [31:0]       memrdata,
   output logic [31:0]       memwdata,
   output logic [1:0]        memlen,
   output logic              memreq,
   output logic              memwr,
   input  logic              memready,
   input  logic              memack
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] END_A  = ADDR_W'(BASE_ADDR + FRAME_WORDS);

   state_t            state_r, state_s;
   logic              memreq_r, memreq_s;
   logic [ADDR_W-1:0] memaddr_r, memaddr_s;
   logic [1:0]        ctr_r, ctr_s;
   logic              sof_b_r, sof_b_s;
   logic              resync_pend_r, resync_pend_s;
   logic              buf_we_s;
   logic              raise_s;
   logic              wren_s;
   logic [PIX_W-1:0]  buf_r [BURST_LEN];
   logic              unused_s;

   // The top byte of each memory word carries no pixel data.
   assign unused_s = ^memrdata[31:24];

   assign wren_s   = (state_r == ST_DRAIN) && !full;
   assign wren     = wren_s;
   assign indat    = {sof_b_r && (ctr_r == 2'd0), buf_r[ctr_r]};
   assign memreq   = memreq_r;
   assign memaddr  = memaddr_r;
   assign memwdata = 32'd0;
   assign memlen   = MEMLEN_BURST;
   assign memwr    = 1'b0;

   // Next-state and next-register logic for the burst FSM.
   always_comb begin
      state_s   = state_r;
      memreq_s  = memreq_r;
      memaddr_s = memaddr_r;
      ctr_s     = ctr_r;
      sof_b_s   = sof_b_r;
      buf_we_s  = 1'b0;
      raise_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               memreq_s = 1'b1;
               raise_s  = 1'b1;
               state_s  = ST_REQ;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (memready) begin
               memreq_s  = 1'b0;
               sof_b_s   = (memaddr_r == BASE_A);
               memaddr_s = next_burst_addr(memaddr_r, BASE_A, END_A);
               ctr_s     = 2'd0;
               state_s   = ST_DAT;
            end else begin
               state_s   = ST_REQ;
            end
         end
         ST_DAT: begin
            if (memack) begin
               buf_we_s = 1'b1;
               ctr_s    = ctr_r + 2'd1;
               state_s  = (ctr_r == LAST_WORD) ? ST_DRAIN : ST_DAT;
            end else begin
               state_s  = ST_DAT;
            end
         end
         ST_DRAIN: begin
            if (wren_s) begin
               ctr_s = ctr_r + 2'd1;
               if (ctr_r == LAST_WORD) begin
                  if (en) begin
                     memreq_s = 1'b1;
                     raise_s  = 1'b1;
                     state_s  = ST_REQ;
                  end else begin
                     state_s  = ST_IDLE;
                  end
               end else begin
                  state_s = ST_DRAIN;
               end
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            memreq_s = 1'b0;
            state_s  = ST_IDLE;
         end
      endcase

      // A resync (pending or arriving now) only takes effect as a new request is raised.
      if (raise_s) begin
         resync_pend_s = 1'b0;
         memaddr_s     = (resync_pend_r || resync) ? BASE_A : memaddr_r;
      end else begin
         resync_pend_s = resync_pend_r || resync;
      end
   end

   // FSM and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         memreq_r      <= 1'b0;
         memaddr_r     <= BASE_A;
         ctr_r         <= 2'd0;
         sof_b_r       <= 1'b0;
         resync_pend_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         memreq_r      <= memreq_s;
         memaddr_r     <= memaddr_s;
         ctr_r         <= ctr_s;
         sof_b_r       <= sof_b_s;
         resync_pend_r <= resync_pend_s;
      end
   end

   // Burst buffer capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BURST_LEN; i++) begin
            buf_r[i] <= '0;
         end
      end else if (buf_we_s) begin
         buf_r[ctr_r] <= memrdata[PIX_W-1:0];
      end else begin
         buf_r <= buf_r;
      end
   end

endmodule

// File: tb/tb_frame_dma_reader.sv
// Directed bench for frame_dma_reader: two instances (8- and 16-word frames) share all
// inputs, so their FSMs run in lockstep while addresses and sof differ.
module tb_frame_dma_reader;

   logic        clk = 1'b0;
   logic        rst_n, en, resync, full, memready, memack;
   logic [31:0] memrdata;
   logic [24:0] indat8, indat16;
   logic        wren8, wren16, req8, req16, wr8, wr16;
   logic [22:0] addr8, addr16;
   logic [31:0] wdat8, wdat16;
   logic [1:0]  len8, len16;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   frame_dma_reader #(.BASE_ADDR(0), .FRAME_WORDS(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .resync(resync), .indat(indat8), .wren(wren8),
      .full(full), .memaddr(addr8), .memrdata(memrdata), .memwdata(wdat8), .memlen(len8),
      .memreq(req8), .memwr(wr8), .memready(memready), .memack(memack));

   frame_dma_reader #(.BASE_ADDR(0), .FRAME_WORDS(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .en(en), .resync(resync), .indat(indat16), .wren(wren16),
      .full(full), .memaddr(addr16), .memrdata(memrdata), .memwdata(wdat16), .memlen(len16),
      .memreq(req16), .memwr(wr16), .memready(memready), .memack(memack));

   typedef struct {
      logic        en, rdy, ack;
      logic [31:0] rdata;
      logic        exp_req, exp_wren;
      logic [24:0] exp_indat;
      logic [22:0] exp_addr;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(input logic e, input logic r, input logic a, input logic [31:0] d,
                               input logic q, input logic w, input logic [24:0] x,
                               input logic [22:0] ad);
      vec_t v;
      v.en = e; v.rdy = r; v.ack = a; v.rdata = d;
      v.exp_req = q; v.exp_wren = w; v.exp_indat = x; v.exp_addr = ad;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input int req_wait, input logic [23:0] seed, input int gap,
                            input bit full_test, input int resync_at, input int drop_en_at,
                            input logic [22:0] a8, input logic [22:0] a16,
                            input bit sof8, input bit sof16);
      int k;
      logic [23:0] pix;
      #1;
      k = 0;
      while (!req8 && k < 30) begin tick(); #1; k++; end
      chk("req_raised", {31'd0, req8}, 32'd1);
      chk("req_addr8", {9'd0, addr8}, {9'd0, a8});
      chk("req_addr16", {9'd0, addr16}, {9'd0, a16});
      repeat (req_wait) tick();
      memready = 1'b1;
      tick();
      memready = 1'b0;
      #1;
      chk("req_dropped", {31'd0, req8}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         repeat (gap) tick();
         if (resync_at == i) resync = 1'b1;
         if (drop_en_at == i) en = 1'b0;
         memack   = 1'b1;
         memrdata = {8'hC3, seed + 24'(i) * 24'h010101};
         tick();
         memack = 1'b0;
         resync = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         k = 0;
         while (!wren8 && k < 10) begin tick(); #1; k++; end
         pix = seed + 24'(i) * 24'h010101;
         chk("drain_wren", {31'd0, wren8}, 32'd1);
         chk("drain_indat8", {7'd0, indat8}, {7'd0, (sof8 && i == 0), pix});
         chk("drain_indat16", {7'd0, indat16}, {7'd0, (sof16 && i == 0), pix});
         tick();
         if (full_test && i == 0) begin
            full = 1'b1;
            for (int j = 0; j < 5; j++) begin
               #1;
               chk("full_hold", {30'd0, wren8, wren16}, 32'd0);
               tick();
            end
            full = 1'b0;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; resync = 1'b0; full = 1'b0;
      memready = 1'b0; memack = 1'b0; memrdata = 32'd0;

      // Reset values
      #3;
      chk("rst_req", {30'd0, req8, req16}, 32'd0);
      chk("rst_wren", {30'd0, wren8, wren16}, 32'd0);
      chk("rst_addr", {9'd0, addr8}, 32'd0);
      chk("rst_len_wr", {26'd0, len8, wr8, wdat8[2:0]}, {26'd0, 2'd3, 1'b0, 3'd0});
      #10 rst_n = 1'b1;
      tick();

      // Single burst at address 0, en dropped once the burst is under way
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 25'h0,       23'd0);
      tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 25'h0,       23'd0);
      tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 25'h0,       23'd0);
      tbl[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 25'h0,       23'd0);
      tbl[4]  = mk(1'b0, 1'b0, 1'b1, 32'hAA112233, 1'b0, 1'b0, 25'h0,       23'd4);
      tbl[5]  = mk(1'b0, 1'b0, 1'b1, 32'h00445566, 1'b0, 1'b0, 25'h0,       23'd4);
      tbl[6]  = mk(1'b0, 1'b0, 1'b1, 32'h00778899, 1'b0, 1'b0, 25'h0,       23'd4);
      tbl[7]  = mk(1'b0, 1'b0, 1'b1, 32'h00AABBCC, 1'b0, 1'b0, 25'h0,       23'd4);
      tbl[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 25'h1112233, 23'd4);
      tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 25'h0445566, 23'd4);
      tbl[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 25'h0778899, 23'd4);
      tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 25'h0AABBCC, 23'd4);
      tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 25'h0,       23'd4);
      for (int i = 0; i < 13; i++) begin
         en = tbl[i].en; memready = tbl[i].rdy; memack = tbl[i].ack; memrdata = tbl[i].rdata;
         #1;
         chk("vec_req", {31'd0, req8}, {31'd0, tbl[i].exp_req});
         chk("vec_wren", {31'd0, wren8}, {31'd0, tbl[i].exp_wren});
         chk("vec_addr8", {9'd0, addr8}, {9'd0, tbl[i].exp_addr});
         chk("vec_addr16", {9'd0, addr16}, {9'd0, tbl[i].exp_addr});
         if (tbl[i].exp_wren) begin
            chk("vec_indat", {7'd0, indat8}, {7'd0, tbl[i].exp_indat});
         end
         tick();
      end
      memack = 1'b0; memready = 1'b0;

      // Asynchronous reset in the middle of a data phase
      en = 1'b1;
      tick();
      memready = 1'b1;
      tick();
      memready = 1'b0;
      memack = 1'b1; memrdata = 32'h00DEAD01;
      tick(); tick();
      memack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", {30'd0, req8, req16}, 32'd0);
      chk("arst_wren", {30'd0, wren8, wren16}, 32'd0);
      chk("arst_addr", {9'd0, addr8}, 32'd0);
      chk("arst_len_wr", {29'd0, len8, wr8}, {29'd0, 2'd3, 1'b0});
      en = 1'b0;
      #2 rst_n = 1'b1;
      tick();

      // Back-to-back bursts: FIFO stall, 8-word wrap, resync on the 16-word frame
      en = 1'b1;
      run_burst(1, 24'h102030, 0, 1'b1, -1, -1, 23'd0, 23'd0,  1'b1, 1'b1);
      run_burst(0, 24'h405060, 1, 1'b0,  1, -1, 23'd4, 23'd4,  1'b0, 1'b0);
      run_burst(2, 24'h708090, 0, 1'b0, -1, -1, 23'd0, 23'd0,  1'b1, 1'b1);
      run_burst(0, 24'hA0B0C0, 2, 1'b0, -1,  1, 23'd4, 23'd4,  1'b0, 1'b0);

      // en dropped mid-burst: back to idle, no new request
      for (int j = 0; j < 5; j++) begin
         #1;
         chk("idle_req", {30'd0, req8, req16}, 32'd0);
         chk("idle_wren", {30'd0, wren8, wren16}, 32'd0);
         tick();
      end
      chk("end_addr8", {9'd0, addr8}, 32'd0);
      chk("end_addr16", {9'd0, addr16}, 32'd8);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
